multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 164 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM: FETCH/DECODE/execute sequencing with memory handshake.
// Optional JAL support is enabled by defining MULTICYCLE_CTRL_JAL_EN.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       zero,
   output logic [1:0] ALUOp,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_EXEC_I   = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      ALUOp     = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      i_or_d    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'b00;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b10;
            case (opcode)
               OP_R:               state_d = S_EXEC_R;
               OP_I:               state_d = S_EXEC_I;
               OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
               OP_BRANCH:          state_d = S_BRANCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
               OP_JAL:             state_d = S_JAL;
`endif
               default:            state_d = S_TRAP;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write = 1'b1;
            wb_sel    = 2'b01;
            state_d   = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            ALUOp     = 2'b10;
            state_d   = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            ALUOp     = 2'b11;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            ALUOp     = 2'b01;
            pc_src    = 1'b1;
            pc_write  = zero;
            state_d   = S_FETCH;
         end
`ifdef MULTICYCLE_CTRL_JAL_EN
         S_JAL: begin
            reg_write = 1'b1;
            wb_sel    = 2'b10;
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            state_d   = S_FETCH;
         end
`endif
         S_TRAP:  state_d = S_TRAP;
         // Unused codes (and JAL when not built in) are treated as illegal.
         default: state_d = S_TRAP;
      endcase

      if (reset) begin
         ALUOp     = 2'b00;
         alu_src_a = 1'b0;
         alu_src_b = 2'b00;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         i_or_d    = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         pc_src    = 1'b0;
         reg_write = 1'b0;
         wb_sel    = 2'b00;
      end
   end

   assign state   = state_q;
   assign illegal = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its expected per-cycle
// control trace from the instruction class and wait counts, then replayed against the DUT.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       zero;
   logic [1:0] ALUOp;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, reg_write;
   logic [1:0] wb_sel;
   logic [3:0] state;
   logic       illegal;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned cyc      = 0;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
      .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
      .state(state), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        z;
      logic [6:0]  op;
      logic [18:0] exp;
   } cyc_t;

   cyc_t plan[$];

   typedef enum int {C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_BAD} cls_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Layout: state, illegal, ALUOp, src_a, src_b, mem_read, mem_write, i_or_d, ir_write,
   // pc_write, pc_src, reg_write, wb_sel
   function automatic logic [18:0] e(input int st, input int aop, input bit a, input int b,
                                     input bit mr, input bit mw, input bit iod, input bit irw,
                                     input bit pcw, input bit pcs, input bit rw, input int wb,
                                     input bit ill);
      return {st[3:0], ill, aop[1:0], a, b[1:0], mr, mw, iod, irw, pcw, pcs, rw, wb[1:0]};
   endfunction

   function automatic cls_t classify(input logic [6:0] op);
      case (op)
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b0000011: return C_LOAD;
         7'b0100011: return C_STORE;
         7'b1100011: return C_BR;
`ifdef MULTICYCLE_CTRL_JAL_EN
         7'b1101111: return C_JAL;
`endif
         default:    return C_BAD;
      endcase
   endfunction

   task automatic add(input logic rst, input logic rdy, input logic z, input logic [6:0] op,
                      input logic [18:0] exp);
      cyc_t c;
      c.rst = rst; c.rdy = rdy; c.z = z; c.op = op; c.exp = exp;
      plan.push_back(c);
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // cut > 0 replaces cycle `cut` of the trace by a reset cycle.
   task automatic build(input logic [6:0] op, input int fw, input int mw, input logic z,
                        input int cut);
      cyc_t        r;
      logic [3:0]  st;
      plan.delete();
      for (int i = 0; i < fw; i++) add(0, 0, rb(), op, e(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(0, 1, rb(), op, e(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0));
      add(0, rb(), rb(), op, e(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      case (classify(op))
         C_R: begin
            add(0, rb(), rb(), op, e(6, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            add(0, rb(), rb(), op, e(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
         end
         C_I: begin
            add(0, rb(), rb(), op, e(7, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            add(0, rb(), rb(), op, e(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
         end
         C_LOAD: begin
            add(0, rb(), rb(), op, e(2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            for (int i = 0; i < mw; i++) add(0, 0, rb(), op, e(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
            add(0, 1, rb(), op, e(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
            add(0, rb(), rb(), op, e(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
         end
         C_STORE: begin
            add(0, rb(), rb(), op, e(2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            for (int i = 0; i < mw; i++) add(0, 0, rb(), op, e(5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
            add(0, 1, rb(), op, e(5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
         end
         C_BR: add(0, rb(), z, op, e(9, 1, 1, 0, 0, 0, 0, 0, z, 1, 0, 0, 0));
         C_JAL: add(0, rb(), rb(), op, e(10, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0));
         default: begin
            for (int i = 0; i < 10; i++) add(0, rb(), rb(), op, e(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            add(1, rb(), rb(), op, e(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
         end
      endcase
      if (cut > 0 && cut < plan.size()) begin
         st = plan[cut].exp[18:15];
         r.rst = 1'b1; r.rdy = rb(); r.z = rb(); r.op = op;
         r.exp = {st, (st == 4'd11), 14'b0};
         plan = plan[0:cut-1];
         plan.push_back(r);
      end
   endtask

   task automatic run_plan();
      foreach (plan[i]) begin
         @(negedge clk);
         reset = plan[i].rst; mem_ready = plan[i].rdy; zero = plan[i].z; opcode = plan[i].op;
         #1;
         check($sformatf("cyc%0d_st%0d", cyc, plan[i].exp[18:15]),
               32'({state, illegal, ALUOp, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d,
                    ir_write, pc_write, pc_src, reg_write, wb_sel}),
               32'(plan[i].exp));
         cyc++;
      end
   endtask

   logic [6:0] ops[7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1101111, 7'b1111111};

   initial begin
      logic [6:0] op;
      reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
      @(posedge clk);
      plan.delete();
      add(1, 1, 1, 7'b0110011, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      run_plan();

      build(7'b0110011, 0, 0, 0, 0); run_plan();   // R-type, no waits
      build(7'b0000011, 0, 2, 0, 0); run_plan();   // load, 2 wait cycles in MEM_RD
      build(7'b1100011, 0, 0, 1, 0); run_plan();   // BEQ taken
      build(7'b1100011, 0, 0, 0, 0); run_plan();   // BEQ not taken
      build(7'b1111111, 0, 0, 0, 0); run_plan();   // illegal -> TRAP -> reset
      build(7'b0100011, 0, 3, 0, 3); run_plan();   // reset during first MEM_WR cycle
      build(7'b0010011, 1, 0, 0, 0); run_plan();
      build(7'b1101111, 0, 0, 0, 0); run_plan();   // JAL or TRAP depending on build
      build(7'b0100011, 0, 0, 0, 0); run_plan();

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) == 0) op = 7'($urandom);
         else op = ops[$urandom_range(0, 6)];
         build(op, $urandom_range(0, 3), $urandom_range(0, 3), rb(),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : 0);
         run_plan();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
